// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive path.
//   state_t      : frame-strip FSM states
//   PREAMBLE_BYTE / SFD_BYTE : GMII framing bytes
//   CRC_*        : Ethernet CRC32 (reflected) polynomial, init value and good-frame residue
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        BODY = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/gmii_rx_frame_strip_if.sv
// Signal bundle between the GMII receive pins, the frame-strip block and the
// downstream logger.
//   gmii_rx_dv/gmii_rx_er/gmii_rxd : raw GMII receive side
//   rx_en/rx_data                  : stripped frame body strobe
//   frame_done/frame_good/frame_len: per-frame verdict
// modport master : PHY/consumer side (drives GMII, observes results)
// modport slave  : the frame-strip block itself
interface gmii_rx_frame_strip_if;

    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic        frame_done;
    logic        frame_good;
    logic [15:0] frame_len;

    modport master (
        output gmii_rx_dv, gmii_rx_er, gmii_rxd,
        input  rx_en, rx_data, frame_done, frame_good, frame_len
    );

    modport slave (
        input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
        output rx_en, rx_data, frame_done, frame_good, frame_len
    );

endinterface

// File: rtl/gmii_rx_frame_strip_crc32_byte.sv
// Combinational byte-wise Ethernet CRC32 update (reflected, LSB first).
// No final inversion: the caller owns init/residue handling, so the same block
// serves the receive checker and the transmit FCS generator.
//   crc_i  : current CRC register
//   data_i : byte to fold in
//   crc_o  : CRC register after the byte
module crc32_byte
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_o = crc_step(crc_i, data_i);

endmodule

// File: rtl/gmii_rx_frame_strip.sv
// GMII receive front-end: finds preamble/SFD, strips preamble, SFD and FCS,
// streams DA..payload on rx_en/rx_data and issues a one-cycle verdict per frame.
//   clk125MHz : GMII receive clock
//   rst       : synchronous active-high reset
//   bus       : GMII inputs and stripped-stream/verdict outputs (slave modport)
module gmii_rx_frame_strip
    import gmii_rx_pkg::*;
#(
    parameter int unsigned MIN_PRE = 1,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic                  clk125MHz,
    input  logic                  rst,
    gmii_rx_frame_strip_if.slave  bus
);

    // input stage: plain pipeline registers, sampled even during reset so the
    // state chosen at reset release lines up with what decode sees next
    logic        dv_q;
    logic        er_q;
    logic [7:0]  rxd_q;

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic        body_byte;
    logic        frame_end;

    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [15:0] byte_cnt_q;
    logic        err_q;

    // 4-byte delay line, index 0 newest; holding back 4 bytes hides the FCS
    logic [3:0][7:0] dl_q;
    logic [3:0][7:0] dl_d;
    logic [2:0]      dl_cnt_q;

    logic        rx_en_q;
    logic [7:0]  rx_data_q;
    logic        frame_done_q;
    logic        frame_good_q;
    logic [15:0] frame_len_q;

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rxd_q),
        .crc_o  (crc_next)
    );

    assign dl_d[0] = rxd_q;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_dl
            assign dl_d[gi] = dl_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk125MHz) begin
        dv_q  <= bus.gmii_rx_dv;
        er_q  <= bus.gmii_rx_er;
        rxd_q <= bus.gmii_rxd;
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        body_byte = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (dv_q) begin
                    if (rxd_q == PREAMBLE_BYTE) begin
                        state_d   = PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PRE: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end else if (rxd_q == PREAMBLE_BYTE) begin
                    if (pre_cnt_q != 4'hF) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end else if ((rxd_q == SFD_BYTE) && (32'(pre_cnt_q) >= MIN_PRE)) begin
                    state_d = BODY;
                end else begin
                    state_d = DROP;
                end
            end
            BODY: begin
                if (dv_q) begin
                    body_byte = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            DROP: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk125MHz) begin
        if (body_byte) begin
            dl_q <= dl_d;
        end
    end

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            // a frame already in flight at release must be ignored entirely
            if (bus.gmii_rx_dv) begin
                state_q <= DROP;
            end else begin
                state_q <= IDLE;
            end
            pre_cnt_q    <= 4'd0;
            crc_q        <= CRC_INIT;
            byte_cnt_q   <= 16'd0;
            err_q        <= 1'b0;
            dl_cnt_q     <= 3'd0;
            rx_en_q      <= 1'b0;
            rx_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            frame_good_q <= 1'b0;
            frame_len_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            frame_done_q <= frame_end;
            frame_good_q <= 1'b0;
            rx_en_q      <= 1'b0;
            rx_data_q    <= 8'h00;
            if (body_byte) begin
                crc_q <= crc_next;
                if (byte_cnt_q != 16'hFFFF) begin
                    byte_cnt_q <= byte_cnt_q + 16'd1;
                end
                err_q <= err_q | er_q;
                if (dl_cnt_q == 3'd4) begin
                    rx_en_q   <= 1'b1;
                    rx_data_q <= dl_q[3];
                end else begin
                    dl_cnt_q <= dl_cnt_q + 3'd1;
                end
            end
            if (frame_end) begin
                frame_good_q <= (crc_q == CRC_RESIDUE) && !err_q &&
                                (32'(byte_cnt_q) >= MIN_LEN) &&
                                (32'(byte_cnt_q) <= MAX_LEN);
                frame_len_q  <= byte_cnt_q;
                crc_q        <= CRC_INIT;
                byte_cnt_q   <= 16'd0;
                err_q        <= 1'b0;
                dl_cnt_q     <= 3'd0;
            end
        end
    end

    assign bus.rx_en      = rx_en_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_good = frame_good_q;
    assign bus.frame_len  = frame_len_q;

endmodule

// File: tb/tb_gmii_rx_frame_strip.sv
// Directed testbench for gmii_rx_frame_strip: good, corrupted, errored, runt,
// short, bad-preamble, back-to-back and mid-frame-reset frames.
module tb_gmii_rx_frame_strip;

    logic clk125MHz = 1'b0;
    logic rst       = 1'b1;

    always #4 clk125MHz = ~clk125MHz;

    gmii_rx_frame_strip_if bus_if ();

    gmii_rx_frame_strip #(
        .MIN_PRE (1),
        .MIN_LEN (64),
        .MAX_LEN (1518)
    ) dut (
        .clk125MHz (clk125MHz),
        .rst       (rst),
        .bus       (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // monitor state
    logic [7:0]  rx_q[$];
    logic        done_good_q[$];
    logic [15:0] done_len_q[$];
    int          en_rises     = 0;
    int          zero_viol    = 0;
    int          overlap_viol = 0;
    int          early_fall   = 0;
    int          post_rst_en  = 0;
    logic        prev_en      = 1'b0;
    bit          rst_window   = 1'b0;

    // stimulus state
    logic [7:0]  frm[$];
    logic [7:0]  exp_out[$];

    always @(negedge clk125MHz) begin
        if (bus_if.rx_en) rx_q.push_back(bus_if.rx_data);
        else if (bus_if.rx_data !== 8'h00) zero_viol <= zero_viol + 1;
        if (bus_if.rx_en && !prev_en) en_rises <= en_rises + 1;
        if (bus_if.frame_done) begin
            done_good_q.push_back(bus_if.frame_good);
            done_len_q.push_back(bus_if.frame_len);
        end
        if (bus_if.frame_done && bus_if.rx_en) overlap_viol <= overlap_viol + 1;
        if (prev_en && !bus_if.rx_en && !bus_if.frame_done && !rst_window)
            early_fall <= early_fall + 1;
        if (rst_window && bus_if.rx_en) post_rst_en <= post_rst_en + 1;
        prev_en <= bus_if.rx_en;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        bus_if.gmii_rx_dv = dv;
        bus_if.gmii_rx_er = er;
        bus_if.gmii_rxd   = d;
        @(posedge clk125MHz);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    // body of n bytes: 0xDE except bytes 3..5 = 00,00,seq; FCS appended
    task automatic make_frame(input int n, input logic [7:0] seq);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        exp_out.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = (i == 3 || i == 4) ? 8'h00 : ((i == 5) ? seq : 8'hDE);
            frm.push_back(b);
            exp_out.push_back(b);
            c = crc_ref(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    endtask

    task automatic send_frame(input int npre, input int er_idx, input int rst_idx);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == rst_idx) begin
                rst = 1'b1;
                drive(1'b1, 1'b0, frm[i]);
                rst = 1'b0;
                rst_window = 1'b1;
            end else begin
                drive(1'b1, (i == er_idx), frm[i]);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        done_good_q.delete();
        done_len_q.delete();
        en_rises     = 0;
        overlap_viol = 0;
        early_fall   = 0;
        post_rst_en  = 0;
    endtask

    task automatic check_frame(input string tag, input int exp_n, input logic exp_good,
                               input logic [15:0] exp_len);
        int bad;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_out.size(); i++)
            if (rx_q[i] !== exp_out[i]) bad++;
        $display("frame %s: bytes=%0d done=%0d good=%0d len=%0d", tag, rx_q.size(),
                 done_good_q.size(), (done_good_q.size() > 0) ? done_good_q[0] : 1'b0,
                 (done_len_q.size() > 0) ? done_len_q[0] : 16'd0);
        chk($sformatf("%s nbytes", tag), rx_q.size(), exp_n);
        chk($sformatf("%s byte_mismatch", tag), bad, 0);
        chk($sformatf("%s rx_en_runs", tag), en_rises, (exp_n > 0) ? 1 : 0);
        chk($sformatf("%s en_done_overlap", tag), overlap_viol, 0);
        chk($sformatf("%s en_early_fall", tag), early_fall, 0);
        chk($sformatf("%s done_count", tag), done_good_q.size(), 1);
        if (done_good_q.size() > 0) begin
            chk($sformatf("%s frame_good", tag), done_good_q[0], exp_good);
            chk($sformatf("%s frame_len", tag), done_len_q[0], exp_len);
        end
    endtask

    initial begin
        int bad_len;
        int good_cnt;

        bus_if.gmii_rx_dv = 1'b0;
        bus_if.gmii_rx_er = 1'b0;
        bus_if.gmii_rxd   = 8'h00;
        rst = 1'b1;
        @(posedge clk125MHz);
        #1;
        idle(3);
        chk("reset rx_en", bus_if.rx_en, 1'b0);
        chk("reset rx_data", bus_if.rx_data, 8'h00);
        chk("reset frame_done", bus_if.frame_done, 1'b0);
        chk("reset frame_good", bus_if.frame_good, 1'b0);
        chk("reset frame_len", bus_if.frame_len, 16'h0000);
        rst = 1'b0;
        idle(3);

        // 1. good frame
        clear_mon();
        make_frame(60, 8'h00);
        send_frame(7, -1, -1);
        idle(6);
        check_frame("good", 60, 1'b1, 16'd64);
        idle(10);
        chk("frame_len held", bus_if.frame_len, 16'd64);
        chk("frame_done low between frames", bus_if.frame_done, 1'b0);

        // 2. bit error in body byte 10
        clear_mon();
        make_frame(60, 8'h01);
        frm[10]     = frm[10] ^ 8'h01;
        exp_out[10] = exp_out[10] ^ 8'h01;
        send_frame(7, -1, -1);
        idle(6);
        check_frame("crc_err", 60, 1'b0, 16'd64);

        // 3a. rx_er on body byte 20
        clear_mon();
        make_frame(60, 8'h02);
        send_frame(7, 20, -1);
        idle(6);
        check_frame("rx_er", 60, 1'b0, 16'd64);

        // 3b. runt: 30 body bytes + valid FCS
        clear_mon();
        make_frame(30, 8'h03);
        send_frame(7, -1, -1);
        idle(6);
        check_frame("runt", 30, 1'b0, 16'd34);

        // short body: 4 bytes, no output, still a verdict
        clear_mon();
        frm.delete();
        exp_out.delete();
        for (int i = 0; i < 4; i++) frm.push_back(8'h11 + 8'(i));
        send_frame(7, -1, -1);
        idle(6);
        check_frame("short", 0, 1'b0, 16'd4);

        // 4. bad preamble, then dv dropped mid-preamble
        clear_mon();
        make_frame(60, 8'h04);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h5D);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm.size(); i++) drive(1'b1, 1'b0, frm[i]);
        idle(2);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        idle(6);
        $display("frame bad_preamble: bytes=%0d done=%0d", rx_q.size(), done_good_q.size());
        chk("bad_pre nbytes", rx_q.size(), 0);
        chk("bad_pre done_count", done_good_q.size(), 0);

        // 5. 80 back-to-back frames, one-cycle IFG
        clear_mon();
        for (int j = 0; j < 80; j++) begin
            make_frame(60, 8'(j));
            send_frame(7, -1, -1);
        end
        idle(6);
        chk("b2b done_count", done_good_q.size(), 80);
        chk("b2b nbytes", rx_q.size(), 4800);
        chk("b2b rx_en_runs", en_rises, 80);
        chk("b2b en_early_fall", early_fall, 0);
        good_cnt = 0;
        bad_len  = 0;
        for (int j = 0; j < done_good_q.size(); j++) begin
            if (done_good_q[j] === 1'b1) good_cnt++;
            if (done_len_q[j] !== 16'd64) bad_len++;
        end
        chk("b2b good_count", good_cnt, 80);
        chk("b2b bad_len", bad_len, 0);
        for (int j = 0; j < 80; j++) begin
            if (rx_q.size() >= (j + 1) * 60) begin
                $display("frame b2b[%0d]: seq=%0d good=%0d", j, rx_q[j*60+5],
                         (j < done_good_q.size()) ? done_good_q[j] : 1'b0);
                chk($sformatf("b2b seq[%0d]", j), rx_q[j*60+5], 8'(j));
            end
        end

        // 6. reset at body byte 30 with dv held high
        clear_mon();
        make_frame(60, 8'h21);
        send_frame(7, -1, 30);
        idle(6);
        $display("frame reset_mid: post_rst_bytes=%0d done=%0d len=%0d",
                 post_rst_en, done_good_q.size(), bus_if.frame_len);
        chk("rst_mid rx_en_after", post_rst_en, 0);
        chk("rst_mid done_count", done_good_q.size(), 0);
        chk("rst_mid frame_len", bus_if.frame_len, 16'd0);
        chk("rst_mid rx_data", bus_if.rx_data, 8'h00);
        rst_window = 1'b0;
        clear_mon();
        make_frame(60, 8'h42);
        send_frame(7, -1, -1);
        idle(6);
        check_frame("after_rst", 60, 1'b1, 16'd64);

        chk("rx_data zero when idle", zero_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
